// File: rtl/neuron_train_driver_pkg.sv
// Shared definitions for the neuron training driver: fixed-point value
// types, the driver FSM state encoding and a small magnitude helper.
package neuron_train_driver_pkg;

    // Unsigned fraction in [0,1]: 8'h00 is 0.0, 8'hFF is ~1.0.
    typedef logic [7:0] zero2one_t;

    // Signed difference of two zero2one_t values (one extra bit for sign).
    typedef logic signed [8:0] frac_t;

    // Driver sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESENT,
        ST_SETTLE,
        ST_LEARN,
        ST_FINISH
    } state_t;

    localparam int ERR_W = 16;

    // |a - b| computed in signed arithmetic; result always fits zero2one_t.
    function automatic zero2one_t abs_diff(input zero2one_t a, input zero2one_t b);
        frac_t d;
        d = frac_t'({1'b0, a}) - frac_t'({1'b0, b});
        return (d < 0) ? zero2one_t'(-d) : zero2one_t'(d);
    endfunction

endpackage

// File: rtl/neuron_train_driver_if.sv
// Sample-load handshake bus between a sample source (master) and the
// training driver (slave).
interface neuron_train_driver_if #(
    parameter int N = 16,
    parameter int M = 25
);
    import neuron_train_driver_pkg::*;

    logic                  load_valid;
    logic                  load_ready;
    zero2one_t [N-1:0]     load_in;
    zero2one_t [M-1:0]     load_expected;

    modport master (
        output load_valid,
        output load_in,
        output load_expected,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_in,
        input  load_expected,
        output load_ready
    );

endinterface

// File: rtl/neuron_train_driver_sample_buffer.sv
// train_sample_buffer: storage for training samples (inputs + targets).
// One synchronous write port, one combinational read port by index.
// Contents are never reset; the fill level is tracked by the driver.
module train_sample_buffer
    import neuron_train_driver_pkg::*;
#(
    parameter int N     = 16,
    parameter int M     = 25,
    parameter int DEPTH = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clock,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  zero2one_t [N-1:0] wr_in,
    input  zero2one_t [M-1:0] wr_exp,
    input  logic [AW-1:0]     raddr,
    output zero2one_t [N-1:0] rd_in,
    output zero2one_t [M-1:0] rd_exp
);

    zero2one_t [N-1:0] mem_in  [DEPTH];
    zero2one_t [M-1:0] mem_exp [DEPTH];

    // Write one sample entry per accepted load.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_in[waddr]  <= wr_in;
            mem_exp[waddr] <= wr_exp;
        end
    end

    assign rd_in  = mem_in[raddr];
    assign rd_exp = mem_exp[raddr];

endmodule

// File: rtl/neuron_train_driver.sv
// neuron_train_driver: replays a buffer of training samples into a neuron
// layer for a number of epochs, presenting each sample, letting the layer
// settle, then pulsing learn. Optional build macro ERR_COUNT_EN adds
// per-sample output comparison and an epoch miss counter on err_count;
// without it err_count is tied to zero and net_out is ignored.
module neuron_train_driver
    import neuron_train_driver_pkg::*;
#(
    parameter int N      = 16,
    parameter int M      = 25,
    parameter int DEPTH  = 8,
    parameter int SETTLE = 2,
    parameter int TOL    = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    neuron_train_driver_if.slave  load,
    input  logic                  clear,
    input  logic                  start,
    input  logic [15:0]           epochs,
    output logic                  busy,
    output logic                  done,
    output logic                  valid,
    output logic                  learn,
    output zero2one_t [N-1:0]     in,
    output zero2one_t [M-1:0]     expected_out,
    input  zero2one_t [M-1:0]     net_out,
    output logic [ERR_W-1:0]      err_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t            state, state_nx;
    logic [CW-1:0]     count, count_eff;
    logic [AW-1:0]     idx;
    logic [15:0]       epoch_cnt, epochs_lat;
    logic [SW-1:0]     settle_cnt;
    logic              wr_en, last_sample, last_epoch, presenting;
    zero2one_t [N-1:0] rd_in;
    zero2one_t [M-1:0] rd_exp;

    train_sample_buffer #(.N(N), .M(M), .DEPTH(DEPTH), .AW(AW)) u_buf (
        .clock  (clock),
        .we     (wr_en),
        .waddr  (count[AW-1:0]),
        .wr_in  (load.load_in),
        .wr_exp (load.load_expected),
        .raddr  (idx),
        .rd_in  (rd_in),
        .rd_exp (rd_exp)
    );

    // Loads are only taken while idle and not full; clear beats a load.
    assign load.load_ready = (state == ST_IDLE) && (count < CW'(DEPTH));
    assign wr_en           = load.load_valid && load.load_ready && !clear;
    // Fill level a coincident start will run with.
    assign count_eff       = clear ? '0 : (wr_en ? count + CW'(1) : count);
    assign last_sample     = (CW'(idx) == count - CW'(1));
    assign last_epoch      = (epoch_cnt == epochs_lat - 16'd1);
    assign presenting      = (state == ST_PRESENT) || (state == ST_SETTLE) ||
                             (state == ST_LEARN);

    assign busy         = (state != ST_IDLE);
    assign done         = (state == ST_FINISH);
    assign valid        = (state == ST_PRESENT);
    assign learn        = (state == ST_LEARN);
    assign in           = presenting ? rd_in  : '0;
    assign expected_out = presenting ? rd_exp : '0;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    // Next-state sequencing: present, settle, learn per sample.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:    if (start) state_nx = (count_eff == '0 || epochs == 16'd0) ?
                                              ST_FINISH : ST_PRESENT;
            ST_PRESENT: state_nx = (SETTLE == 0) ? ST_LEARN : ST_SETTLE;
            ST_SETTLE:  if (settle_cnt == SW'(SETTLE - 1)) state_nx = ST_LEARN;
            ST_LEARN:   state_nx = (last_sample && last_epoch) ? ST_FINISH : ST_PRESENT;
            ST_FINISH:  state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // Buffer fill level, sample index, epoch and settle counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count      <= '0;
            idx        <= '0;
            epoch_cnt  <= '0;
            epochs_lat <= '0;
            settle_cnt <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (clear)      count <= '0;
                    else if (wr_en) count <= count + CW'(1);
                    if (start) begin
                        epochs_lat <= epochs;
                        idx        <= '0;
                        epoch_cnt  <= '0;
                    end
                end
                ST_PRESENT: settle_cnt <= '0;
                ST_SETTLE:  settle_cnt <= settle_cnt + SW'(1);
                ST_LEARN: begin
                    if (last_sample) begin
                        idx       <= '0;
                        epoch_cnt <= epoch_cnt + 16'd1;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ERR_COUNT_EN
    logic [M-1:0]      lane_miss;
    logic              sample_miss;
    logic [ERR_W-1:0]  miss_cnt, miss_total;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v, input logic inc);
        return (inc && v != {ERR_W{1'b1}}) ? v + ERR_W'(1) : v;
    endfunction

    // Per-neuron tolerance check of the layer output against the target.
    always_comb begin
        lane_miss = '0;
        for (int j = 0; j < M; j++)
            lane_miss[j] = abs_diff(net_out[j], expected_out[j]) > zero2one_t'(TOL);
    end

    assign sample_miss = |lane_miss;
    assign miss_total  = sat_inc(miss_cnt, sample_miss);

    // Accumulate misses over an epoch and publish at the epoch boundary.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            miss_cnt  <= '0;
            err_count <= '0;
        end else if (state == ST_IDLE && start) begin
            miss_cnt <= '0;
        end else if (state == ST_LEARN) begin
            if (last_sample) begin
                err_count <= miss_total;
                miss_cnt  <= '0;
            end else begin
                miss_cnt <= miss_total;
            end
        end
    end
`else
    logic unused_net_out;
    assign unused_net_out = ^net_out;
    assign err_count      = '0;
`endif

endmodule

// File: tb/tb_neuron_train_driver.sv
// Directed, self-checking bench for neuron_train_driver with a queue
// scoreboard of expected sample indices consumed at each valid pulse.
module tb_neuron_train_driver;
    import neuron_train_driver_pkg::*;

    localparam int N = 16, M = 25, DEPTH = 8, SETTLE = 2, TOL = 0;
    localparam int SPS = SETTLE + 2;

    typedef zero2one_t [N-1:0] in_vec_t;
    typedef zero2one_t [M-1:0] exp_vec_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0, start = 1'b0;
    logic [15:0] epochs = 16'd0;
    logic        busy, done, valid, learn;
    in_vec_t     dut_in;
    exp_vec_t    expected_out, net_out;
    logic [15:0] err_count;

    always #5 clock = ~clock;

    neuron_train_driver_if #(.N(N), .M(M)) lif ();

    neuron_train_driver #(.N(N), .M(M), .DEPTH(DEPTH), .SETTLE(SETTLE), .TOL(TOL)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .load         (lif),
        .clear        (clear),
        .start        (start),
        .epochs       (epochs),
        .busy         (busy),
        .done         (done),
        .valid        (valid),
        .learn        (learn),
        .in           (dut_in),
        .expected_out (expected_out),
        .net_out      (net_out),
        .err_count    (err_count)
    );

    in_vec_t     m_in  [DEPTH];
    exp_vec_t    m_exp [DEPTH];
    int          m_count = 0;
    logic [15:0] m_err = 16'd0;
    int          q[$];
    int          n_tests = 0, n_fail = 0;
    logic        bad_mode = 1'b0;
    exp_vec_t    bad_target = '0;

    // Layer model: echoes the target, 1 LSB off on neuron 0 for the chosen sample.
    always_comb begin
        net_out = expected_out;
        if (bad_mode && expected_out == bad_target)
            net_out[0] = expected_out[0] + 8'd1;
    end

    function automatic in_vec_t gen_in(input int k);
        in_vec_t v;
        for (int i = 0; i < N; i++) v[i] = 8'((k * 37 + i * 11 + 3) % 256);
        return v;
    endfunction

    function automatic exp_vec_t gen_exp(input int k);
        exp_vec_t v;
        for (int j = 0; j < M; j++) v[j] = 8'((k * 53 + j * 7 + 1) % 250);
        return v;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input int k);
        lif.load_in       = gen_in(k);
        lif.load_expected = gen_exp(k);
        lif.load_valid    = 1'b1;
        check("load_ready", 256'(lif.load_ready), 256'(m_count < DEPTH));
        if (m_count < DEPTH) begin
            m_in[m_count]  = gen_in(k);
            m_exp[m_count] = gen_exp(k);
            m_count++;
        end
        tick();
        lif.load_valid = 1'b0;
    endtask

    // Start a run and check every cycle; stop_k > 0 returns early at that cycle.
    task automatic run(input int eps, input int stop_k, input bit disturb);
        int cnt, total, miss, cur, phase;
        logic [15:0] exp_err;
        cnt   = m_count;
        total = (eps == 0 || cnt == 0) ? 0 : cnt * eps * SPS;
        miss  = 0;
        cur   = 0;
        for (int e = 0; e < eps && cnt > 0; e++)
            for (int s = 0; s < cnt; s++) q.push_back(s);
        for (int s = 0; s < cnt; s++) if (bad_mode && s == 1) miss++;
        epochs = 16'(eps);
        start  = 1'b1;
        tick();
        start          = 1'b0;
        lif.load_valid = 1'b0;
        for (int k = 1; k <= total + 2; k++) begin
            if (k == stop_k) return;
            phase = (k - 1) % SPS;
            if (k <= total) begin
                check("valid", 256'(valid), 256'(phase == 0));
                check("learn", 256'(learn), 256'(phase == SPS - 1));
                check("busy_run", 256'(busy), 256'(1'b1));
                check("done_run", 256'(done), 256'(1'b0));
                check("ready_busy", 256'(lif.load_ready), 256'(1'b0));
                if (phase == 0) begin
                    check("queue_nonempty", 256'(q.size() > 0), 256'(1'b1));
                    if (q.size() > 0) cur = q.pop_front();
                end
                check("in", 256'(dut_in), 256'(m_in[cur]));
                check("expected_out", 256'(expected_out), 256'(m_exp[cur]));
            end else if (k == total + 1) begin
                check("done_pulse", 256'(done), 256'(1'b1));
                check("busy_finish", 256'(busy), 256'(1'b1));
                check("valid_finish", 256'({valid, learn}), 256'(2'b00));
            end else begin
                check("done_after", 256'(done), 256'(1'b0));
                check("busy_after", 256'(busy), 256'(1'b0));
                check("ready_idle", 256'(lif.load_ready), 256'(m_count < DEPTH));
            end
            if (disturb && k == 3) begin
                start = 1'b1; clear = 1'b1; epochs = 16'd7;
                lif.load_valid = 1'b1; lif.load_in = '1; lif.load_expected = '1;
            end else if (disturb && k == 4) begin
                start = 1'b0; clear = 1'b0; lif.load_valid = 1'b0;
            end
            tick();
        end
        if (total > 0) m_err = 16'(miss);
`ifdef ERR_COUNT_EN
        exp_err = m_err;
`else
        exp_err = 16'd0;
`endif
        check("err_count", 256'(err_count), 256'(exp_err));
        check("queue_drained", 256'(q.size()), 256'(0));
    endtask

    initial begin
        lif.load_valid    = 1'b0;
        lif.load_in       = '0;
        lif.load_expected = '0;

        // Reset state
        repeat (2) tick();
        check("rst_busy", 256'(busy), 256'(1'b0));
        check("rst_flags", 256'({valid, learn, done}), 256'(3'b000));
        check("rst_in", 256'(dut_in), 256'(0));
        check("rst_expected_out", 256'(expected_out), 256'(0));
        check("rst_err_count", 256'(err_count), 256'(0));
        check("rst_load_ready", 256'(lif.load_ready), 256'(1'b1));
        reset_n = 1'b1;
        tick();

        // Three samples, two epochs; then rerun while poking inputs
        for (int k = 0; k < 3; k++) load(k);
        run(2, 0, 1'b0);
        run(2, 0, 1'b1);

        // One sample off by 1 LSB, then all matching
        bad_target = m_exp[1];
        bad_mode   = 1'b1;
        run(1, 0, 1'b0);
        bad_mode   = 1'b0;
        run(1, 0, 1'b1);

        // epochs == 0
        run(0, 0, 1'b0);

        // Fill to DEPTH, a ninth load is dropped
        for (int k = 3; k < 8; k++) load(k);
        check("full_ready", 256'(lif.load_ready), 256'(1'b0));
        load(99);
        run(1, 0, 1'b0);

        // clear alone, one load, then clear beats a coincident load
        clear = 1'b1; tick(); clear = 1'b0; m_count = 0;
        load(20);
        lif.load_in = gen_in(21); lif.load_expected = gen_exp(21);
        lif.load_valid = 1'b1; clear = 1'b1;
        tick();
        lif.load_valid = 1'b0; clear = 1'b0; m_count = 0;
        run(1, 0, 1'b0);

        // start coincident with a load uses the new count
        lif.load_in = gen_in(8); lif.load_expected = gen_exp(8);
        lif.load_valid = 1'b1;
        m_in[0] = gen_in(8); m_exp[0] = gen_exp(8); m_count = 1;
        run(1, 0, 1'b0);

        // Reset during SETTLE of sample 1
        load(9);
        load(10);
        run(1, 7, 1'b0);
        reset_n = 1'b0;
        #1;
        check("abort_busy", 256'(busy), 256'(1'b0));
        check("abort_flags", 256'({valid, learn, done}), 256'(3'b000));
        check("abort_in", 256'(dut_in), 256'(0));
        check("abort_expected_out", 256'(expected_out), 256'(0));
        check("abort_err_count", 256'(err_count), 256'(0));
        check("abort_load_ready", 256'(lif.load_ready), 256'(1'b1));
        m_count = 0;
        m_err   = 16'd0;
        q.delete();
        tick();
        reset_n = 1'b1;
        tick();
        run(1, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/neuron_train_driver.md
NEURON_TRAIN_DRIVER -- requirements
Module: neuron_train_driver

Interface
REQ-001 Parameter N, default 16: inputs per sample, equal to the driven layer's fan-in.
REQ-002 Parameter M, default 25: neurons in the driven layer.
REQ-003 Parameter DEPTH, default 8: sample buffer entries.
REQ-004 Parameter SETTLE, default 2: cycles `in` is held before `learn`.
REQ-005 Parameter TOL, default 0: per-neuron miss tolerance, in zero2one_t LSBs.
REQ-006 Ports SHALL be:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load_valid  in  1  sample write request.
- load_ready  out  1  buffer accepts a sample.
- load_in  in  zero2one_t[N]  sample inputs.
- load_expected  in  zero2one_t[M]  sample targets.
- clear  in  1  empties the buffer; honoured only in IDLE.
- start  in  1  begins training; honoured only in IDLE.
- epochs  in  16  passes over the buffer, sampled on start.
- busy  out  1  training in progress.
- done  out  1  one-cycle completion pulse.
- valid  out  1  to layer valid.
- learn  out  1  to layer learn.
- in  out  zero2one_t[N]  to layer in.
- expected_out  out  zero2one_t[M]  to layer expected_out.
- net_out  in  zero2one_t[M]  from layer out.
- err_count  out  16  missed samples in the last completed epoch.

Function
REQ-007 The block SHALL use the FSM states IDLE, PRESENT, SETTLE, LEARN and FINISH.
REQ-008 In IDLE, load_ready SHALL equal (count < DEPTH).
REQ-009 A load_valid && load_ready cycle SHALL write entry[count] and increment count; load_ready SHALL be 0 outside IDLE.
REQ-010 In IDLE, clear SHALL set count to 0; when clear and load_valid coincide, clear wins and nothing is written.
REQ-011 In IDLE, start with count==0 or epochs==0 SHALL go to FINISH.
REQ-012 In IDLE, any other start SHALL latch epochs, zero the sample index and epoch counter, and go to PRESENT.
REQ-013 When start and load_valid coincide, the load SHALL be accepted first, and the new count is used for the run.
REQ-014 PRESENT SHALL last 1 cycle with valid=1 and in/expected_out = entry[idx]; it then goes to SETTLE.
REQ-015 SETTLE SHALL last SETTLE cycles with valid=0 and in/expected_out held; it then goes to LEARN.
REQ-016 LEARN SHALL last 1 cycle with learn=1, in/expected_out held, and net_out compared.
REQ-017 From LEARN, idx SHALL wrap to 0 and the epoch counter SHALL increment at idx==count-1.
REQ-018 From LEARN, the next state SHALL be FINISH when the final epoch completes, otherwise PRESENT.
REQ-019 Each sample SHALL therefore take SETTLE+2 cycles.
REQ-020 A sample miss SHALL be counted when |net_out[j] - expected_out[j]| > TOL for any j.
REQ-021 The epoch miss counter SHALL saturate at 16'hFFFF and copy into err_count at epoch end, then zero.
REQ-022 FINISH SHALL last 1 cycle with done=1, then return to IDLE.
REQ-023 busy SHALL be 1 in all states except IDLE.
REQ-024 start, clear and load_valid SHALL be ignored outside IDLE.
REQ-025 Buffer contents and count SHALL survive a completed run.

Reset
REQ-026 reset_n low SHALL force IDLE, even mid-run.
REQ-027 Reset SHALL zero count, idx, the epoch counter and err_count.
REQ-028 During reset, valid, learn, done and busy SHALL be 0, and in and expected_out SHALL be all-zero.
REQ-029 Buffer RAM contents SHALL NOT be reset; they are undefined until loaded.

Configuration
REQ-030 With ERR_COUNT_EN defined, the comparators and miss counter SHALL exist, and err_count behaves per REQ-020 and REQ-021.
REQ-031 With ERR_COUNT_EN undefined, no comparison logic SHALL be built, err_count SHALL be constant 0, and net_out SHALL be unused.

Structure
REQ-032 zero2one_t and frac_t SHALL stay in the shared defs package.
REQ-033 The FSM state enum SHALL be added to the shared defs package.
REQ-034 The sample buffer SHALL be a separate sub-module, train_sample_buffer.
REQ-035 train_sample_buffer SHALL provide a synchronous write port and a combinational read by index, with count owned by the driver.

Verification (N=16, M=25, DEPTH=8, SETTLE=2, TOL=0)
REQ-036 Load 3 samples, then start with epochs=2 -> busy for 24 cycles, valid pulses at cycles 1, 5 and 9 of each epoch, learn at cycles 4, 8 and 12, then a single done pulse.
REQ-037 Load 8 samples -> load_ready=0 after the 8th; a 9th load_valid is dropped and count stays 8.
REQ-038 Start with count==0, or with epochs==0 -> done the next cycle, no valid and no learn.
REQ-039 net_out equal to target for samples 0 and 2 and off by 1 LSB for sample 1, epochs=1 -> err_count=1 after done; rerun with net_out matching all -> err_count=0.
REQ-040 reset_n low during SETTLE of sample 1 -> IDLE, all outputs 0, count=0 immediately; the next start goes to FINISH.
REQ-041 start, clear and load_valid all asserted while busy -> run unaffected and buffer unchanged.
